// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: single-cycle add/sub/logic, iterative one-bit-per-cycle shifts.
// Result and N/Z/V/C are registered and written only on the edge that enters DONE.
module alu_exec_unit #(
   parameter int unsigned n = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   input  logic [2:0]   OP,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] Result,
   output logic         N,
   output logic         Z,
   output logic         V,
   output logic         C
);

   localparam int unsigned sw = $clog2(n);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LSL = 3'b101;
   localparam logic [2:0] OP_LSR = 3'b110;
   localparam logic [2:0] OP_ASR = 3'b111;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state_q, state_nxt;
   logic [2:0]      op_q;
   logic [n-1:0]    work_q;
   logic [sw-1:0]   cnt_q;

   logic            accept_c;
   logic            is_shift_c;
   logic [sw-1:0]   amt_c;
   logic [n:0]      sum_c;
   logic [n-1:0]    res_c;
   logic            v_c;
   logic            c_c;
   logic [n-1:0]    step_c;
   logic            out_bit_c;

   assign accept_c   = in_valid && in_ready;
   assign is_shift_c = OP[2] && (OP[1] || OP[0]);
   assign amt_c      = B[sw-1:0];

   // Single-cycle result from the live request inputs; shifts by zero pass A through.
   always_comb begin
      sum_c = '0;
      res_c = A;
      v_c   = 1'b0;
      c_c   = 1'b0;
      case (OP)
         OP_ADD: begin
            sum_c = {1'b0, A} + {1'b0, B};
            res_c = sum_c[n-1:0];
            c_c   = sum_c[n];
            v_c   = (A[n-1] == B[n-1]) && (sum_c[n-1] != A[n-1]);
         end
         OP_SUB: begin
            sum_c = {1'b0, A} + {1'b0, ~B} + (n+1)'(1);
            res_c = sum_c[n-1:0];
            c_c   = sum_c[n];
            v_c   = (A[n-1] != B[n-1]) && (sum_c[n-1] != A[n-1]);
         end
         OP_AND:  res_c = A & B;
         OP_OR:   res_c = A | B;
         OP_XOR:  res_c = A ^ B;
         default: res_c = A;
      endcase
   end

   // One-bit shift step of the working register, with the bit that falls off.
   always_comb begin
      step_c    = work_q;
      out_bit_c = 1'b0;
      case (op_q)
         OP_LSL: begin
            step_c    = {work_q[n-2:0], 1'b0};
            out_bit_c = work_q[n-1];
         end
         OP_LSR: begin
            step_c    = {1'b0, work_q[n-1:1]};
            out_bit_c = work_q[0];
         end
         OP_ASR: begin
            step_c    = {work_q[n-1], work_q[n-1:1]};
            out_bit_c = work_q[0];
         end
         default: begin
            step_c    = work_q;
            out_bit_c = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               if (is_shift_c && (amt_c != '0)) state_nxt = SHIFT;
               else                             state_nxt = DONE;
            end
         end
         SHIFT: begin
            if (cnt_q == sw'(1)) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are pure state decodes; ready is also forced low during reset.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      in_ready  = rst_n && (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= OP_ADD;
         work_q <= '0;
         cnt_q  <= '0;
         Result <= '0;
         N      <= 1'b0;
         Z      <= 1'b0;
         V      <= 1'b0;
         C      <= 1'b0;
      end else if (accept_c) begin
         op_q   <= OP;
         work_q <= A;
         cnt_q  <= is_shift_c ? amt_c : '0;
         if (!is_shift_c || (amt_c == '0)) begin
            Result <= res_c;
            N      <= res_c[n-1];
            Z      <= (res_c == '0);
            V      <= v_c;
            C      <= c_c;
         end
      end else if (state_q == SHIFT) begin
         work_q <= step_c;
         cnt_q  <= cnt_q - sw'(1);
         // Final step publishes the shifted value and the last bit shifted out.
         if (cnt_q == sw'(1)) begin
            Result <= step_c;
            N      <= step_c[n-1];
            Z      <= (step_c == '0);
            V      <= 1'b0;
            C      <= out_bit_c;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (n = 32).
// Expected results and flags are hand-computed constants.
module tb_alu_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  OP;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Result;
   logic        N, Z, V, C;

   int total = 0;
   int bad   = 0;

   alu_exec_unit #(.n(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .OP(OP), .out_valid(out_valid), .out_ready(out_ready),
      .Result(Result), .N(N), .Z(Z), .V(V), .C(C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request, measure latency, check response, consume it.
   task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                      input int el);
      int lat;
      in_valid = 1'b1;
      OP = op; A = a; B = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = $urandom; B = $urandom; OP = 3'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(el));
      chk({tag, "_res"}, Result, er);
      chk({tag, "_nzvc"}, 32'({N, Z, V, C}), 32'(ef));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ovld_after"}, 32'(out_valid), 32'd0);
      chk({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; OP = 3'b000;
      #12;
      chk("rst_ovld", 32'(out_valid), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd0);
      chk("rst_res", Result, 32'h0);
      chk("rst_nzvc", 32'({N, Z, V, C}), 32'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_rdy", 32'(in_ready), 32'd1);

      run("add_1",   3'b000, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 4'b1000, 0);
      run("sub_1",   3'b001, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 4'b1001, 0);
      run("sub_eq",  3'b001, 32'd5,        32'd5,        32'h00000000, 4'b0101, 0);
      run("sub_brw", 3'b001, 32'd0,        32'd1,        32'hFFFFFFFF, 4'b1000, 0);
      run("add_ovf", 3'b000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b1010, 0);
      run("add_cry", 3'b000, 32'hFFFFFFFF, 32'd1,        32'h00000000, 4'b0101, 0);
      run("and",     3'b010, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 4'b1000, 0);
      run("or",      3'b011, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 4'b1000, 0);
      run("xor",     3'b100, 32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 4'b0100, 0);
      run("lsl4",    3'b101, 32'h80000001, 32'd4,        32'h00000010, 4'b0000, 4);
      run("lsr1",    3'b110, 32'h00000003, 32'd1,        32'h00000001, 4'b0001, 1);
      run("asr31",   3'b111, 32'h80000000, 32'd31,       32'hFFFFFFFF, 4'b1000, 31);
      run("lsl0",    3'b101, 32'h12345678, 32'h20,       32'h12345678, 4'b0000, 0);
      run("lsr31",   3'b110, 32'h80000000, 32'd31,       32'h00000001, 4'b0000, 31);

      // Backpressure: response held while a new request waits.
      in_valid = 1'b1; OP = 3'b000; A = 32'd2; B = 32'd3;
      @(posedge clk); #1;
      OP = 3'b001; A = 32'd10; B = 32'd4;
      chk("bp_ovld0", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_res", Result, 32'd5);
         chk("bp_hold_nzvc", 32'({N, Z, V, C}), 32'h0);
         chk("bp_hold_rdy", 32'(in_ready), 32'd0);
         chk("bp_hold_ovld", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_consumed_ovld", 32'(out_valid), 32'd0);
      chk("bp_consumed_rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_new_ovld", 32'(out_valid), 32'd1);
      chk("bp_new_res", Result, 32'd6);
      chk("bp_new_nzvc", 32'({N, Z, V, C}), 32'(4'b0001));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset in the middle of an LSR by 10.
      in_valid = 1'b1; OP = 3'b110; A = 32'hFFFFFFFF; B = 32'd10;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_res", Result, 32'h0);
      chk("mid_rst_nzvc", 32'({N, Z, V, C}), 32'h0);
      chk("mid_rst_ovld", 32'(out_valid), 32'd0);
      chk("mid_rst_rdy", 32'(in_ready), 32'd0);
      @(posedge clk); @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid) cyc++;
      end
      chk("mid_rst_no_resp", 32'(cyc), 32'd0);
      run("add_after_rst", 3'b000, 32'd2, 32'd3, 32'd5, 4'b0000, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
